// File: rtl/poly_stream_encoder.sv
// Streaming packer: scales input words into polynomial coefficients, then holds one frame for downstream.
// Optional build macro ENC_MOD_REDUCE_EN: a single conditional subtract of Q on each stored coefficient.
module poly_stream_encoder #(
  parameter int POLY_SIZE    = 16,
  parameter int INPUT_WIDTH  = 16,
  parameter int SCALE_FACTOR = 2,
  parameter int Q            = 132097
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [INPUT_WIDTH-1:0]                           in_data,
  input  logic                                             in_last,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [(INPUT_WIDTH+SCALE_FACTOR)*POLY_SIZE-1:0]  poly_coeff,
  output logic [$clog2(POLY_SIZE+1)-1:0]                   out_count,
  output logic                                             o_dbg_state
);

  localparam int CW   = INPUT_WIDTH + SCALE_FACTOR;
  localparam int IW   = $clog2(POLY_SIZE);
  localparam int CNTW = $clog2(POLY_SIZE+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(POLY_SIZE - 1);

  // Handshakes: a word moves when in_valid & in_ready at a rising edge; a frame
  // moves when out_valid & out_ready. in_ready and out_valid are never both high.
  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [CNTW-1:0]   r_count;
  logic [CW-1:0]     r_coeff [POLY_SIZE];

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_close;
  logic [CW-1:0]     w_scaled;
  logic [CW-1:0]     w_store;

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;
  assign w_close  = w_in_hs & (in_last | (r_idx == LAST_IDX));
  assign w_scaled = CW'(in_data) << SCALE_FACTOR;

`ifdef ENC_MOD_REDUCE_EN
  localparam logic [CW-1:0] Q_VAL = CW'(Q);
  assign w_store = (w_scaled >= Q_VAL) ? (w_scaled - Q_VAL) : w_scaled;
`else
  logic w_unused_q;
  assign w_unused_q = |Q;
  assign w_store    = w_scaled;
`endif

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (w_close) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // The index stays on the closing slot so it never leaves 0..POLY_SIZE-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_count <= '0;
      for (int i = 0; i < POLY_SIZE; i++) r_coeff[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_out_hs) begin
        r_idx   <= '0;
        r_count <= '0;
        for (int i = 0; i < POLY_SIZE; i++) r_coeff[i] <= '0;
      end else if (w_in_hs) begin
        r_coeff[r_idx] <= w_store;
        if (w_close) r_count <= CNTW'(r_idx) + CNTW'(1);
        else         r_idx   <= r_idx + IW'(1);
      end
    end
  end

  for (genvar g = 0; g < POLY_SIZE; g++) begin : g_pack
    assign poly_coeff[g*CW +: CW] = r_coeff[g];
  end

  assign out_count   = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_poly_stream_encoder.sv
// Scoreboard bench for poly_stream_encoder: random frames and back-pressure against an array-based frame model.
module tb_poly_stream_encoder;

  localparam int PS   = 16;
  localparam int IWD  = 16;
  localparam int SF   = 2;
  localparam int QM   = 132097;
  localparam int CW   = IWD + SF;
  localparam int CNTW = $clog2(PS+1);
  localparam int W    = CNTW + CW*PS;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IWD-1:0]  in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW*PS-1:0] poly_coeff;
  logic [CNTW-1:0] out_count;
  logic            dbg_state;

  poly_stream_encoder #(
    .POLY_SIZE(PS), .INPUT_WIDTH(IWD), .SCALE_FACTOR(SF), .Q(QM)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .poly_coeff(poly_coeff), .out_count(out_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int frames_in  = 0;
  int frames_out = 0;
  int or_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit gap_en  = 1'b0;
  bit post_hs = 1'b0;

  logic [W-1:0]   exp_q[$];
  logic [IWD-1:0] wbuf[PS];

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] model_coeff(input logic [IWD-1:0] d);
    longint v;
    v = longint'(d) * (longint'(1) << SF);
`ifdef ENC_MOD_REDUCE_EN
    if (v >= QM) v = v - QM;
`endif
    return CW'(v);
  endfunction

  function automatic logic [W-1:0] model_frame(input int len);
    logic [W-1:0] e;
    e = '0;
    for (int i = 0; i < len; i++) e[i*CW +: CW] = model_coeff(wbuf[i]);
    e[W-1 -: CNTW] = CNTW'(len);
    return e;
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- input driver tasks ----------------
  task automatic drive_word(input logic [IWD-1:0] d, input logic l);
    bit got;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL in_accept_timeout got=in_ready_low required=accept_within_300");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Frame of len words from wbuf; the final word carries in_last when fin_last is set.
  task automatic send_frame(input int len, input logic fin_last);
    for (int i = 0; i < len; i++)
      drive_word(wbuf[i], (i == len-1) ? fin_last : 1'b0);
    exp_q.push_back(model_frame(len));
    frames_in++;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL close_latency got out_valid=%b required=1", out_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total += 4;
    if (in_ready !== 1'b1)   begin bad++; $display("FAIL %s_in_ready got=%b required=1", tag, in_ready); end
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL %s_out_valid got=%b required=0", tag, out_valid); end
    if (poly_coeff !== '0)   begin bad++; $display("FAIL %s_poly_coeff got=%h required=0", tag, poly_coeff); end
    if (out_count !== '0)    begin bad++; $display("FAIL %s_out_count got=%0d required=0", tag, out_count); end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (in_ready !== !out_valid || dbg_state !== out_valid) begin
        bad++;
        $display("FAIL state_outputs got in_ready=%b out_valid=%b state=%b required exclusive",
                 in_ready, out_valid, dbg_state);
      end
      if (post_hs) begin
        post_hs = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL after_out_hs got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame got count=%0d required=no_frame", out_count);
        end else begin
          if ({out_count, poly_coeff} !== exp_q[0]) begin
            bad++;
            $display("FAIL frame_data got=%h required=%h", {out_count, poly_coeff}, exp_q[0]);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            frames_out++;
            post_hs = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    // Full frame of 0..15 with no in_last: coefficient i = 4*i, count 16.
    for (int i = 0; i < PS; i++) wbuf[i] = IWD'(i);
    send_frame(PS, 1'b0);

    // Short frame closed by in_last: 12, 20, 28, rest zero.
    wbuf[0] = 16'h0003; wbuf[1] = 16'h0005; wbuf[2] = 16'h0007;
    send_frame(3, 1'b1);

    // Extreme word and smallest nonzero word.
    wbuf[0] = 16'hFFFF;
    send_frame(1, 1'b1);
    wbuf[0] = 16'h0001;
    send_frame(1, 1'b1);

    // Sixteenth word with in_last high also closes exactly one frame.
    for (int i = 0; i < PS; i++) wbuf[i] = IWD'($urandom);
    send_frame(PS, 1'b1);

    // Held frame: downstream stalled while the source keeps offering words.
    repeat (3) begin @(posedge clk); #1; end
    or_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < PS; i++) wbuf[i] = IWD'($urandom);
    send_frame(PS, 1'b0);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = IWD'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_in_ready got=%b required=0", in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    or_mode  = 0;

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) drive_word(IWD'($urandom), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midreset");
    for (int i = 0; i < PS; i++) wbuf[i] = IWD'($urandom);
    send_frame(PS, 1'b0);

    // Random frames with random gaps and back-pressure.
    gap_en  = 1'b1;
    or_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      logic fl;
      len = $urandom_range(1, PS);
      for (int i = 0; i < len; i++) wbuf[i] = IWD'($urandom);
      fl = (len < PS) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(len, fl);
    end

    // Drain and account for every frame.
    or_mode = 0;
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d required=0", exp_q.size());
    end
    total++;
    if (frames_out != frames_in) begin
      bad++;
      $display("FAIL frame_count got=%0d required=%0d", frames_out, frames_in);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_stream_encoder.md
POLY_STREAM_ENCODER -- requirements
Module: poly_stream_encoder

Interface
REQ-001 Parameter POLY_SIZE, default 16: number of polynomial coefficients per frame, range 2..256.
REQ-002 Parameter INPUT_WIDTH, default 16: width of each input data word.
REQ-003 Parameter SCALE_FACTOR, default 2: left-shift applied to each word; coefficient width CW = INPUT_WIDTH+SCALE_FACTOR.
REQ-004 Parameter Q, default 132097: reduction modulus, used only when ENC_MOD_REDUCE_EN is defined; legal range 2^(CW-1) <= Q < 2^CW.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: in_data/in_last are valid.
REQ-008 Port in_ready, output, 1: block accepts a word this cycle.
REQ-009 Port in_data, input, INPUT_WIDTH: binary data word.
REQ-010 Port in_last, input, 1: the accepted word is the last of the frame.
REQ-011 Port out_valid, output, 1: poly_coeff/out_count hold a complete frame.
REQ-012 Port out_ready, input, 1: downstream consumes the frame.
REQ-013 Port poly_coeff, output, CW*POLY_SIZE: packed coefficients; coefficient i occupies bits [(i+1)*CW-1 : i*CW].
REQ-014 Port out_count, output, $clog2(POLY_SIZE+1): number of coefficients loaded from input, 1..POLY_SIZE.

Function
REQ-015 The FSM SHALL have exactly two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-017 On an input handshake in FILL, coefficient[idx] SHALL be written with in_data zero-extended to CW bits and shifted left by SCALE_FACTOR, and idx SHALL increment.
REQ-018 FILL->HOLD occurs on the input handshake where in_last=1 or idx=POLY_SIZE-1; out_valid SHALL assert on the next cycle (latency 1 cycle from the final word).
REQ-019 On early in_last (idx<POLY_SIZE-1), the coefficients above idx SHALL read zero in the HOLD frame, and out_count SHALL equal idx+1.
REQ-020 In HOLD, poly_coeff and out_count SHALL remain stable until the output handshake; in_data is ignored.
REQ-021 HOLD->FILL occurs on the output handshake; all coefficients and idx clear to 0 the same edge; in_ready rises next cycle (one-cycle bubble, no overlap).
REQ-022 in_valid=0 in FILL SHALL leave all state unchanged; no timeout.
REQ-023 idx SHALL never exceed POLY_SIZE-1; no wrap-around within a frame.
REQ-024 Without a preceding in_last, the POLY_SIZE-th word SHALL close the frame regardless of its in_last value.

Reset
REQ-025 While reset=1 at a rising edge: state=FILL, idx=0, all coefficients=0, out_count=0; outputs after that edge: in_ready=1, out_valid=0, poly_coeff=0.
REQ-026 Reset SHALL take priority over any simultaneous handshake; a partial or held frame SHALL be discarded.

Configuration
REQ-027 Macro ENC_MOD_REDUCE_EN: when defined, each scaled value v SHALL be stored as (v>=Q) ? v-Q : v (single conditional subtract, same cycle, no added latency).
REQ-028 When ENC_MOD_REDUCE_EN is undefined, the scaled value SHALL be stored unreduced and Q SHALL be unused.

Verification
REQ-029 Reset, then 16 words 0x0000..0x000F with in_last=0 -> one cycle after word 15: out_valid=1, coefficient i = 4*i, out_count=16.
REQ-030 Words 0x0003, 0x0005, 0x0007 with in_last on the third -> coefficients 12, 20, 28, rest 0; out_count=3.
REQ-031 Frame held with out_ready=0 for 10 cycles while in_valid=1 with varying data -> poly_coeff is unchanged and in_ready=0 throughout; after out_ready=1: one output handshake, then in_ready=1 the following cycle.
REQ-032 reset asserted after 5 accepted words, then a full 16-word frame -> the output frame contains only the post-reset words; out_count=16.
REQ-033 ENC_MOD_REDUCE_EN defined, word 0xFFFF -> coefficient 130043; word 0x0001 -> coefficient 4. ENC_MOD_REDUCE_EN undefined, word 0xFFFF -> coefficient 262140.
REQ-034 Random in_valid/out_ready back-pressure over 1000 frames against a scoreboard -> no frame lost, duplicated or corrupted.
